// File: rtl/player_pkg.sv
// Shared types and constants for the platformer player controller.
package player_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WALK    = 4'd1,
        ST_JUMP    = 4'd2,
        ST_FALL    = 4'd3,
        ST_ATTACK  = 4'd4,
        ST_RESPAWN = 4'd5,
        ST_DEAD    = 4'd6
    } status_t;

    localparam logic [7:0] KEY_LEFT_DEF   = 8'h50;
    localparam logic [7:0] KEY_RIGHT_DEF  = 8'h4F;
    localparam logic [7:0] KEY_DOWN_DEF   = 8'h51;
    localparam logic [7:0] KEY_JUMP_DEF   = 8'h52;
    localparam logic [7:0] KEY_ATTACK_DEF = 8'h1B;

endpackage

// File: rtl/frame_down_counter.sv
// Per-frame down counter: load has priority, otherwise decrements while non-zero.
module frame_down_counter #(
    parameter int W = 8
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: reload, decrement (saturating at zero) or hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/player_ctrl.sv
// Player controller: keycode-driven movement/state FSM updated once per video frame.
module player_ctrl
    import player_pkg::*;
#(
    parameter int X_CENTER      = 320,
    parameter int Y_CENTER      = 377,
    parameter int SIZE_X        = 30,
    parameter int SIZE_Y        = 62,
    parameter int X_MIN         = 31,
    parameter int X_MAX         = 607,
    parameter int Y_MIN         = 100,
    parameter int Y_MAX         = 451,
    parameter int FLOOR_Y       = 408,
    parameter int LEFT_EDGE     = 116,
    parameter int RIGHT_EDGE    = 523,
    parameter int SPEED_X       = 2,
    parameter int SPEED_Y       = 6,
    parameter int JUMP_FRAMES   = 27,
    parameter int ATTACK_FRAMES = 8,
    parameter int INVULN_FRAMES = 60,
    parameter int LIVES         = 3,
    parameter int DEAD_Y        = 215,
    parameter logic [7:0] KEY_LEFT   = KEY_LEFT_DEF,
    parameter logic [7:0] KEY_RIGHT  = KEY_RIGHT_DEF,
    parameter logic [7:0] KEY_DOWN   = KEY_DOWN_DEF,
    parameter logic [7:0] KEY_JUMP   = KEY_JUMP_DEF,
    parameter logic [7:0] KEY_ATTACK = KEY_ATTACK_DEF
) (
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [7:0]         keycode,
    input  logic               hit,
    output logic [COORD_W-1:0] PlayerX,
    output logic [COORD_W-1:0] PlayerY,
    output logic [COORD_W-1:0] Player_Size_X,
    output logic [COORD_W-1:0] Player_Size_Y,
    output logic [3:0]         Player_Status,
    output logic [3:0]         Player_Life,
    output logic               Inverse,
    output logic               Invuln
);

    localparam int SW = COORD_W + 1;
    localparam int JW = $clog2(JUMP_FRAMES + 1);
    localparam int AW = $clog2(ATTACK_FRAMES + 1);
    localparam int IW = $clog2(INVULN_FRAMES + 1);

    localparam logic signed [SW-1:0] HX      = SW'(SIZE_X / 2);
    localparam logic signed [SW-1:0] HY      = SW'(SIZE_Y / 2);
    localparam logic signed [SW-1:0] X_LO    = SW'(X_MIN + SIZE_X / 2);
    localparam logic signed [SW-1:0] X_HI    = SW'(X_MAX - SIZE_X / 2);
    localparam logic signed [SW-1:0] Y_TOP   = SW'(Y_MIN + SIZE_Y / 2);
    localparam logic signed [SW-1:0] PLAT_L  = SW'(LEFT_EDGE);
    localparam logic signed [SW-1:0] PLAT_R  = SW'(RIGHT_EDGE);
    localparam logic signed [SW-1:0] FLOOR_S = SW'(FLOOR_Y);
    localparam logic signed [SW-1:0] PIT_S   = SW'(Y_MAX);
    localparam logic signed [SW-1:0] DX      = SW'(SPEED_X);
    localparam logic signed [SW-1:0] DY      = SW'(SPEED_Y);

    localparam logic [COORD_W-1:0] X_SPAWN = COORD_W'(X_CENTER);
    localparam logic [COORD_W-1:0] Y_SPAWN = COORD_W'(Y_CENTER);
    localparam logic [COORD_W-1:0] Y_DEAD  = COORD_W'(DEAD_Y);

    status_t              state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [3:0]           life_q, life_d;
    logic                 inverse_q, inverse_d;

    logic                 jumpLoad, jumpDec, jumpZero;
    logic [JW-1:0]        jumpCnt;
    logic                 atkLoad, atkDec, atkZero;
    logic [AW-1:0]        atkCnt;
    logic                 invLoad, invZero;
    logic [IW-1:0]        invCnt;

    logic                 keyLeft, keyRight, keyDown, keyJump, keyAttack;
    logic signed [SW-1:0] xCur, xMoved, yCur, yRise, yFall;
    logic                 riseClamped, onPlatNext, jumpRelease, jumpLast, atkLast;
    logic                 pitLoss, hitEff, loseLife;

    assign keyLeft   = (keycode == KEY_LEFT);
    assign keyRight  = (keycode == KEY_RIGHT);
    assign keyDown   = (keycode == KEY_DOWN);
    assign keyJump   = (keycode == KEY_JUMP);
    assign keyAttack = (keycode == KEY_ATTACK);

    assign jumpRelease = !(keyJump || keyLeft || keyRight);
    assign jumpLast    = jumpZero || (jumpCnt == JW'(1));
    assign atkLast     = atkZero || (atkCnt == AW'(1));
    assign hitEff      = hit && invZero && !(state_q inside {ST_RESPAWN, ST_DEAD});

    // Candidate positions: steered and clamped X, clamped rise and unclamped fall for Y.
    always_comb begin
        xCur = $signed({1'b0, x_q});
        yCur = $signed({1'b0, y_q});
        xMoved = xCur;
        if (keyLeft) begin
            xMoved = xCur - DX;
        end else if (keyRight) begin
            xMoved = xCur + DX;
        end
        if (xMoved < X_LO) begin
            xMoved = X_LO;
        end else if (xMoved > X_HI) begin
            xMoved = X_HI;
        end
        onPlatNext = ((xMoved + HX) >= PLAT_L) && ((xMoved - HX) <= PLAT_R);
        yRise = yCur - DY;
        riseClamped = 1'b0;
        if (yRise < Y_TOP) begin
            yRise = Y_TOP;
            riseClamped = 1'b1;
        end
        yFall = yCur + DY;
    end

    // Next-state logic: movement per state, then damage/pit loss overrides.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        life_d    = life_q;
        inverse_d = inverse_q;
        jumpLoad  = 1'b0;
        jumpDec   = 1'b0;
        atkLoad   = 1'b0;
        atkDec    = 1'b0;
        invLoad   = 1'b0;
        pitLoss   = 1'b0;
        loseLife  = 1'b0;

        if (state_q inside {ST_IDLE, ST_WALK, ST_JUMP, ST_FALL}) begin
            x_d = xMoved[COORD_W-1:0];
            if (keyLeft) begin
                inverse_d = 1'b1;
            end else if (keyRight) begin
                inverse_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE, ST_WALK: begin
                if (!onPlatNext) begin
                    state_d = ST_FALL;
                end else if (keyJump) begin
                    state_d  = ST_JUMP;
                    jumpLoad = 1'b1;
                    y_d      = yRise[COORD_W-1:0];
                end else if (keyAttack) begin
                    state_d = ST_ATTACK;
                    atkLoad = 1'b1;
                end else if (keyLeft || keyRight) begin
                    state_d = ST_WALK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_JUMP: begin
                jumpDec = 1'b1;
                if (jumpRelease || keyDown || jumpLast) begin
                    state_d = ST_FALL;
                end else begin
                    y_d = yRise[COORD_W-1:0];
                    if (riseClamped) begin
                        state_d = ST_FALL;
                    end
                end
            end
            ST_FALL: begin
                if (onPlatNext && ((yFall + HY) >= FLOOR_S)) begin
                    y_d     = Y_SPAWN;
                    state_d = ST_IDLE;
                end else begin
                    y_d = yFall[COORD_W-1:0];
                    if ((yFall + HY) > PIT_S) begin
                        pitLoss = 1'b1;
                    end
                end
            end
            ST_ATTACK: begin
                atkDec = 1'b1;
                if (atkLast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESPAWN: begin
                x_d       = X_SPAWN;
                y_d       = Y_SPAWN;
                inverse_d = 1'b0;
                invLoad   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hitEff) begin
            invLoad = 1'b1;
        end
        loseLife = hitEff || pitLoss;
        if (loseLife) begin
            life_d = (life_q != 4'd0) ? (life_q - 4'd1) : 4'd0;
            if (life_d == 4'd0) begin
                state_d = ST_DEAD;
                x_d     = X_SPAWN;
                y_d     = Y_DEAD;
            end else if (pitLoss) begin
                state_d = ST_RESPAWN;
            end
        end
    end

    // State and output registers, returned to spawn values by the asynchronous reset.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            x_q       <= X_SPAWN;
            y_q       <= Y_SPAWN;
            life_q    <= 4'(LIVES);
            inverse_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            life_q    <= life_d;
            inverse_q <= inverse_d;
        end
    end

    frame_down_counter #(.W(JW)) u_jumpCnt (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load_i    (jumpLoad),
        .value_i   (JW'(JUMP_FRAMES)),
        .dec_i     (jumpDec),
        .count_o   (jumpCnt),
        .zero_o    (jumpZero)
    );

    frame_down_counter #(.W(AW)) u_atkCnt (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load_i    (atkLoad),
        .value_i   (AW'(ATTACK_FRAMES)),
        .dec_i     (atkDec),
        .count_o   (atkCnt),
        .zero_o    (atkZero)
    );

    frame_down_counter #(.W(IW)) u_invCnt (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load_i    (invLoad),
        .value_i   (IW'(INVULN_FRAMES)),
        .dec_i     (1'b1),
        .count_o   (invCnt),
        .zero_o    (invZero)
    );

    assign PlayerX       = x_q;
    assign PlayerY       = y_q;
    assign Player_Size_X = COORD_W'(SIZE_X);
    assign Player_Size_Y = COORD_W'(SIZE_Y);
    assign Player_Status = state_q;
    assign Player_Life   = life_q;
    assign Inverse       = inverse_q;
    assign Invuln        = (invCnt != '0);

endmodule
